// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: arbiter state encoding, decoder opcodes and
// the data word returned on an aborted memory access.
package risc_toy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_I_REQ = 3'd1,
        ST_I_RSP = 3'd2,
        ST_D_REQ = 3'd3,
        ST_D_RSP = 3'd4
    } arb_state_e;

    // Major opcodes decoded by the pipeline.
    localparam logic [4:0] OP_ADDI = 5'd0;
    localparam logic [4:0] OP_J    = 5'd14;
    localparam logic [4:0] OP_BR   = 5'd15;
    localparam logic [4:0] OP_LD   = 5'd19;
    localparam logic [4:0] OP_ST   = 5'd21;

    // Returned on a timed-out access so the pipeline never deadlocks.
    localparam logic [31:0] ERR_DATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/risc_toy_arb_pick.sv
// Combinational fetch/data priority select. Data wins a tie unless fetch has
// already been passed over STARVE_MAX times in a row.
module risc_toy_arb_pick
    import risc_toy_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int SW         = 2
) (
    input  logic          ireq_i,
    input  logic          dreq_i,
    input  logic [SW-1:0] starve_i,
    output logic          grant_i_o,
    output logic          grant_d_o
);

    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    // Data priority, overridden once the fetch side has starved long enough.
    always_comb begin
        grant_d_o = dreq_i && !(ireq_i && (starve_i == STARVE_TOP));
        grant_i_o = ireq_i && !grant_d_o;
    end

endmodule

// File: rtl/risc_toy_mem_arbiter.sv
// Unified single-port memory sequencer for the RISC_TOY fetch and data ports.
// One transaction in flight; done pulses and memory-side outputs are registered.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | no access in flight; arbitrates unless a done is pulsing
// ST_I_REQ | fetch request on MREQ, waiting for MACK
// ST_I_RSP | fetch accepted, waiting for MRVALID
// ST_D_REQ | data request on MREQ, waiting for MACK
// ST_D_RSP | data read accepted, waiting for MRVALID
module risc_toy_mem_arbiter
    import risc_toy_pkg::*;
#(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IREQ,
    input  logic [AW-1:0] IADDR,
    output logic [DW-1:0] INSTR,
    output logic          IDONE,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DWDATA,
    output logic [DW-1:0] DRDATA,
    output logic          DDONE,
    output logic          MREQ,
    output logic          MRW,
    output logic [AW-1:0] MADDR,
    output logic [DW-1:0] MWDATA,
    input  logic          MACK,
    input  logic          MRVALID,
    input  logic [DW-1:0] MRDATA,
    output logic          STALL_IF,
    output logic          STALL_MEM,
    output logic          ERR
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit            TMO_EN     = (TIMEOUT > 0);
    localparam logic [DW-1:0] ERR_WORD   = DW'(ERR_DATA);

    arb_state_e    state_q, state_d;
    logic          mreq_q, mreq_d;
    logic          mrw_q, mrw_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mwdata_q, mwdata_d;
    logic          idone_q, idone_d;
    logic          ddone_q, ddone_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          grant_i, grant_d;
    logic          arb_ok;
    logic          tmo_hit;
    logic          abort;

    // A pulsing done means the requester still holds the finished request, so
    // IDLE waits one cycle rather than granting it a second time.
    assign arb_ok  = (state_q == ST_IDLE) && !idone_q && !ddone_q;
    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

    risc_toy_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_pick (
        .ireq_i    (IREQ),
        .dreq_i    (DREQ),
        .starve_i  (starve_q),
        .grant_i_o (grant_i),
        .grant_d_o (grant_d)
    );

    // Next-state, memory-side outputs, capture and timeout handling.
    always_comb begin
        state_d  = state_q;
        mreq_d   = mreq_q;
        mrw_d    = mrw_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        idone_d  = 1'b0;
        ddone_d  = 1'b0;
        instr_d  = instr_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q + TW'(1);
        abort    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_ok && grant_d) begin
                    state_d  = ST_D_REQ;
                    mreq_d   = 1'b1;
                    mrw_d    = DRW;
                    maddr_d  = DADDR;
                    mwdata_d = DWDATA;
                end else if (arb_ok && grant_i) begin
                    state_d  = ST_I_REQ;
                    mreq_d   = 1'b1;
                    mrw_d    = 1'b0;
                    maddr_d  = IADDR;
                end
            end
            ST_I_REQ: begin
                if (MACK) begin
                    mreq_d = 1'b0;
                    if (MRVALID) begin
                        instr_d = MRDATA;
                        idone_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_I_RSP;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            ST_I_RSP: begin
                if (MRVALID) begin
                    instr_d = MRDATA;
                    idone_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            ST_D_REQ: begin
                if (MACK) begin
                    mreq_d = 1'b0;
                    if (mrw_q) begin
                        ddone_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (MRVALID) begin
                        drdata_d = MRDATA;
                        ddone_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_D_RSP;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            ST_D_RSP: begin
                if (MRVALID) begin
                    drdata_d = MRDATA;
                    ddone_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mreq_d  = 1'b0;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            mreq_d  = 1'b0;
            err_d   = 1'b1;
            if (state_q == ST_I_REQ || state_q == ST_I_RSP) begin
                idone_d = 1'b1;
                instr_d = ERR_WORD;
            end else begin
                ddone_d  = 1'b1;
                drdata_d = ERR_WORD;
            end
        end

        if (state_q == ST_IDLE || state_d != state_q) begin
            tmo_d = '0;
        end
    end

    // Count data grants that pass over a waiting fetch; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!IREQ || (arb_ok && grant_i)) begin
            starve_d = '0;
        end else if (arb_ok && grant_d && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            mreq_q   <= 1'b0;
            mrw_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            instr_q  <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            mrw_q    <= mrw_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            idone_q  <= idone_d;
            ddone_q  <= ddone_d;
            instr_q  <= instr_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
        end
    end

    assign MREQ      = mreq_q;
    assign MRW       = mrw_q;
    assign MADDR     = maddr_q;
    assign MWDATA    = mwdata_q;
    assign INSTR     = instr_q;
    assign IDONE     = idone_q;
    assign DRDATA    = drdata_q;
    assign DDONE     = ddone_q;
    assign ERR       = err_q;
    assign STALL_IF  = IREQ & ~idone_q;
    assign STALL_MEM = DREQ & ~ddone_q;

endmodule

// File: doc/risc_toy_mem_arbiter.md
Name: risc_toy_mem_arbiter

Overview:
- Sequences one unified single-port memory between the RISC_TOY instruction-fetch port (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA).
- Arbitrates the two ports with data priority and a bounded fetch-starvation guarantee.
- Runs one outstanding memory transaction at a time, returns read data with done pulses, and drives the stall signals the pipeline uses to freeze IF and MEM.

Parameters:
- AW, 30: word-address width.
- DW, 32: data width.
- STARVE_MAX, 3: maximum consecutive data grants while a fetch is waiting. The next arbitration then goes to fetch.
- TIMEOUT, 64: cycles allowed in a wait state before abort. 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- IREQ  in  1  fetch request. Held until IDONE.
- IADDR  in  AW  fetch word address.
- INSTR  out  DW  fetched instruction. Valid while IDONE=1.
- IDONE  out  1  fetch complete, one-cycle pulse.
- DREQ  in  1  data request. Held until DDONE.
- DRW  in  1  1=write, 0=read.
- DADDR  in  AW  data word address.
- DWDATA  in  DW  write data.
- DRDATA  out  DW  load data. Valid while DDONE=1.
- DDONE  out  1  data access complete, one-cycle pulse.
- MREQ  out  1  memory request, registered.
- MRW  out  1  memory write, registered.
- MADDR  out  AW  memory address, registered.
- MWDATA  out  DW  memory write data, registered.
- MACK  in  1  memory accepted the request this cycle.
- MRVALID  in  1  memory read data valid.
- MRDATA  in  DW  memory read data.
- STALL_IF  out  1  equals IREQ & ~IDONE (combinational).
- STALL_MEM  out  1  equals DREQ & ~DDONE (combinational).
- ERR  out  1  sticky timeout flag. Cleared only by RST.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE.
  - MREQ, MRW, IDONE, DDONE, ERR = 0.
  - MADDR, MWDATA, INSTR, DRDATA = 0.
  - starve and timeout counters = 0.
  - Reset mid-transaction drops MREQ at that edge. Any later MRVALID is ignored in IDLE.
- States: IDLE, I_REQ, I_RSP, D_REQ, D_RSP.
- IDLE arbitration:
  - DREQ only: go to D_REQ.
  - IREQ only: go to I_REQ.
  - Both pending: data wins unless starve==STARVE_MAX, in which case fetch wins.
  - On the grant edge: latch address, DRW and DWDATA into MADDR, MRW and MWDATA; assert MREQ. MRW=0 for fetch.
- starve counter:
  - +1 on each data grant while IREQ=1.
  - Cleared on a fetch grant or when IREQ=0.
  - Saturates at STARVE_MAX.
- X_REQ (X = I or D):
  - MREQ held stable until MACK=1.
  - Write + MACK: MREQ=0, DDONE=1 for one cycle, next state IDLE.
  - Read + MACK: MREQ=0, go to X_RSP.
  - Read + MACK + MRVALID in the same cycle: complete directly (done pulse, data captured), go to IDLE.
- X_RSP:
  - Wait for MRVALID.
  - On MRVALID: capture MRDATA into INSTR or DRDATA, pulse IDONE or DDONE, go to IDLE.
- Latency with MACK in the grant+1 cycle and MRVALID one cycle later:
  - Read: done 3 cycles after the grant edge.
  - Write: done 2 cycles after the grant edge.
  - IDLE always costs 1 cycle between transactions, so no back-to-back grants.
- Done pulses are registered. The requester may drop or change its request in the cycle after done. The arbiter never regrants the same request: it returns to IDLE before resampling IREQ/DREQ.
- MRVALID outside X_RSP/X_REQ and MACK outside X_REQ are ignored.
- Timeout (TIMEOUT>0):
  - Counter runs in any non-IDLE state and clears on state entry.
  - At count==TIMEOUT-1: go to IDLE, MREQ=0, ERR=1, and pulse the matching done with data = 32'hDEAD_DEAD so the pipeline does not deadlock.
- INSTR and DRDATA hold their last captured value between done pulses.

Decomposition:
- Shared package (risc_toy_pkg): state encoding, the opcode constants already used by the pipeline decoder, and the ERR_DATA constant 32'hDEAD_DEAD.
- One natural sub-module: risc_toy_arb_pick, the combinational priority/starvation select. Inputs IREQ, DREQ, starve, STARVE_MAX. Outputs grant_i, grant_d.
- The FSM and counters stay in the top.

Test Plan:
- Fetch only, IADDR=30'h10, MACK 1 cycle after MREQ, MRVALID +1 with MRDATA=32'h1234_5678 → IDONE pulse with INSTR=32'h1234_5678. STALL_IF high until that cycle. MRW=0 throughout.
- Data write, DADDR=30'h20, DWDATA=32'hCAFE_0001, MACK delayed 3 cycles → MREQ/MRW/MADDR/MWDATA stable for 4 cycles, DDONE one cycle after MACK, no MRVALID needed.
- IREQ and DREQ held continuously, STARVE_MAX=3 → grant order D,D,D,I,D,D,D,I…; no fetch waits more than 3 data transactions.
- Read with MACK and MRVALID in the same cycle, MRDATA=32'h0000_00FF → DDONE next cycle with DRDATA=32'hFF; D_RSP never entered.
- TIMEOUT=8, MACK held 0 → abort after 8 cycles: MREQ=0, ERR=1 (sticky), DDONE pulse with DRDATA=32'hDEAD_DEAD. Next request still serviced.
- RST=1 during I_RSP, then MRVALID arrives → MREQ=0 and state IDLE after the reset edge, no IDONE, INSTR=0, ERR=0.
